xext_bus_master: RTL
====================

Name: xext_bus_master

Overview:
- Single-outstanding initiator for the external peripheral bus. Drives the address, read strobe and write strobe that the external address decoder consumes, and returns the muxed read data.
- Accepts commands from the core over a valid/ready handshake.
- Sequences setup, wait and strobe phases.
- Returns one response per command over a valid/ready handshake.

Parameters:
- WAIT_CYCLES, 1, cycles ext_addr is held stable with both strobes low before the strobe cycle; legal range 0..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_we  input  1  1 = write, 0 = read
- cmd_addr  input  `EXT_ADDR_W  target peripheral address
- cmd_wdata  input  `DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  output  `DATA_W  read data; 0 for writes
- rsp_err  output  1  command rejected (see Optional Feature)
- ext_addr  output  `EXT_ADDR_W  bus address to decoder
- ext_rd_en  output  1  read strobe
- ext_wr_en  output  1  write strobe
- ext_wdata  output  `DATA_W  bus write data
- ext_rdata  input  `DATA_W  decoder data_out (combinational from ext_addr/ext_rd_en)

Behaviour:
- Reset: all outputs are registered and clear to 0 asynchronously on rst_n low; state = IDLE; wait counter = 0.
  - Exception: cmd_ready is combinational (state==IDLE) and is therefore 1 during and after reset.
- Reset mid-transaction aborts the transaction immediately. Strobes drop asynchronously. No response is produced.
- FSM states are IDLE, SETUP, STROBE and RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_addr into ext_addr, cmd_wdata into ext_wdata (writes only) and cmd_we internally.
  - Load counter = WAIT_CYCLES.
  - Go to SETUP if WAIT_CYCLES>0, else go to STROBE.
- SETUP:
  - Strobes low; counter decrements each cycle.
  - Go to STROBE in the cycle counter reaches 1. The address is therefore stable for exactly WAIT_CYCLES cycles before the strobe.
- STROBE:
  - Exactly one cycle with ext_wr_en=cmd_we or ext_rd_en=!cmd_we. Never both.
  - On a read, sample ext_rdata into rsp_rdata at the end of this cycle.
  - On a write, clear rsp_rdata to 0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err stable until accepted.
  - On rsp_ready, clear rsp_valid next cycle and go to IDLE.
  - rsp_ready may be held high permanently.
- ext_addr and ext_wdata hold their last values in IDLE; they change only on command accept.
- Latency with WAIT_CYCLES=1 and rsp_ready=1 (accept in cycle 0):
  - SETUP is cycle 1, strobe is cycle 2, rsp_valid is high in cycle 3.
  - Next accept can occur in cycle 4, so throughput is one command per WAIT_CYCLES+3 cycles.
- cmd_valid outside IDLE is ignored (cmd_ready=0). The requester must hold its command stable until accepted.
- Data width: ext_rdata is taken whole; no sign/zero manipulation.

Optional Feature:
- Macro: XEXT_ADDR_CHECK_EN.
- Defined:
  - On accept, the command is checked against the peripheral map:
    - writes are legal only to `LED_BASE and `DISPLAY0..`DISPLAY3;
    - reads are legal only from `SWITCH_BASE, `BUTTON_BASE and `LFSR_BASE.
  - An illegal command goes IDLE→RESP directly, with no SETUP/STROBE and no strobe asserted, and ext_addr unchanged. It responds with rsp_err=1 and rsp_rdata=0.
  - Legal commands respond with rsp_err=0.
- Not defined:
  - rsp_err is tied to 0.
  - Every command runs SETUP/STROBE regardless of address; the decoder ignores unmapped accesses, and unmapped reads return 0.

Test Plan:
- Reset/idle: rst_n low for 3 cycles with cmd_valid=1 → strobes 0, rsp_valid 0, ext_addr 0; after release, cmd_ready=1 and the command is accepted on the first clk edge.
- Write timing, WAIT_CYCLES=1: write `DISPLAY2, data 0x5 at cycle 0 →
  - ext_addr=`DISPLAY2 from cycle 1;
  - ext_wr_en=1 only in cycle 2 with ext_wdata=0x5;
  - rsp_valid in cycle 3 with rsp_rdata=0.
- Read capture: read `SWITCH_BASE with ext_rdata modelled as 0x2A during the strobe cycle and 0x00 otherwise → rsp_rdata=0x2A; exactly one ext_rd_en pulse.
- Backpressure: read `BUTTON_BASE (0x9) with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata=0x9 held; cmd_ready=0 throughout; a second cmd_valid is not accepted until 1 cycle after the rsp_ready handshake.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: strobe arrives in cycle 1 and cycle 16 after accept respectively; address stable across all intermediate cycles.
- Mid-op reset and address check (with XEXT_ADDR_CHECK_EN):
  - rst_n low during SETUP → no strobe and no response, FSM back in IDLE.
  - Write to `SWITCH_BASE → no strobe, rsp_err=1 one cycle after accept.
  - Read `LFSR_BASE → rsp_err=0.

Source files
------------

// File: rtl/xext_bus_master.sv
// xext_bus_master: single-outstanding initiator for the external peripheral bus.
// Optional macro XEXT_ADDR_CHECK_EN rejects commands outside the peripheral map with rsp_err.
`ifndef EXT_ADDR_W
`define EXT_ADDR_W 8
`endif
`ifndef DATA_W
`define DATA_W 8
`endif
`ifndef SWITCH_BASE
`define SWITCH_BASE 8'h10
`endif
`ifndef BUTTON_BASE
`define BUTTON_BASE 8'h11
`endif
`ifndef LFSR_BASE
`define LFSR_BASE 8'h12
`endif
`ifndef LED_BASE
`define LED_BASE 8'h20
`endif
`ifndef DISPLAY0
`define DISPLAY0 8'h30
`endif
`ifndef DISPLAY1
`define DISPLAY1 8'h31
`endif
`ifndef DISPLAY2
`define DISPLAY2 8'h32
`endif
`ifndef DISPLAY3
`define DISPLAY3 8'h33
`endif

module xext_bus_master #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [`EXT_ADDR_W-1:0] cmd_addr,
  input  logic [`DATA_W-1:0]     cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [`DATA_W-1:0]     rsp_rdata,
  output logic                   rsp_err,
  output logic [`EXT_ADDR_W-1:0] ext_addr,
  output logic                   ext_rd_en,
  output logic                   ext_wr_en,
  output logic [`DATA_W-1:0]     ext_wdata,
  input  logic [`DATA_W-1:0]     ext_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [`EXT_ADDR_W-1:0] addr_q, addr_d;
  logic [`DATA_W-1:0]     wdata_q, wdata_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [`DATA_W-1:0]     rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   cmd_legal;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef XEXT_ADDR_CHECK_EN
  // Writes target only the LED and display registers; reads only the input devices.
  always_comb begin
    if (cmd_we) begin
      cmd_legal = (cmd_addr == `LED_BASE) || (cmd_addr == `DISPLAY0) ||
                  (cmd_addr == `DISPLAY1) || (cmd_addr == `DISPLAY2) ||
                  (cmd_addr == `DISPLAY3);
    end else begin
      cmd_legal = (cmd_addr == `SWITCH_BASE) || (cmd_addr == `BUTTON_BASE) ||
                  (cmd_addr == `LFSR_BASE);
    end
  end
`else
  assign cmd_legal = 1'b1;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!cmd_legal) begin
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
            state_d     = ST_RESP;
          end else begin
            addr_d = cmd_addr;
            we_d   = cmd_we;
            err_d  = 1'b0;
            cnt_d  = WAIT_LD;
            if (cmd_we) wdata_d = cmd_wdata;
            if (WAIT_LD == 4'd0) begin
              // No setup phase: the strobe register loads on the accept edge.
              state_d = ST_STROBE;
              rd_en_d = !cmd_we;
              wr_en_d = cmd_we;
            end else begin
              state_d = ST_SETUP;
            end
          end
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_STROBE;
          rd_en_d = !we_q;
          wr_en_d = we_q;
        end
      end
      ST_STROBE: begin
        rdata_d     = we_q ? '0 : ext_rdata;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together;
  // the asynchronous reset also drops strobes mid-transaction without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;
  assign ext_rd_en = rd_en_q;
  assign ext_wr_en = wr_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
